// File: rtl/id_stage_hz_if.sv
// id_stage_hz_if: groups the decode stage's upstream, write-back and ID/EX
// signals so they travel as one bundle.
//   slave  modport : the decode stage (consumes if_*, flush, wb_*; drives
//                    id_ready, ex_*, stall_count)
//   master modport : the environment around the stage (the opposite view)
// Handshake: upstream presents if_valid with if_instr/if_pc_plus4; the
// instruction is taken on a rising clk edge only when id_ready is 1, otherwise
// upstream must hold it unchanged for the next cycle.
interface id_stage_hz_if #(
    parameter int XLEN   = 32,
    parameter int SCNT_W = 16
);
    logic              if_valid;
    logic [31:0]       if_instr;
    logic [XLEN-1:0]   if_pc_plus4;
    logic              id_ready;
    logic              flush;
    logic              wb_reg_write;
    logic [4:0]        wb_waddr;
    logic [XLEN-1:0]   wb_wd;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_rs_val;
    logic [XLEN-1:0]   ex_rt_val;
    logic [XLEN-1:0]   ex_imm_ext;
    logic [4:0]        ex_shamt;
    logic [4:0]        ex_rs;
    logic [4:0]        ex_rt;
    logic [4:0]        ex_rd;
    logic              ex_is_load;
    logic [XLEN-1:0]   ex_pc_plus4;
    logic [XLEN-1:0]   ex_jump_target;
    logic [SCNT_W-1:0] stall_count;

    modport slave (
        input  if_valid, if_instr, if_pc_plus4, flush,
        input  wb_reg_write, wb_waddr, wb_wd,
        output id_ready, ex_valid, ex_rs_val, ex_rt_val, ex_imm_ext, ex_shamt,
        output ex_rs, ex_rt, ex_rd, ex_is_load, ex_pc_plus4, ex_jump_target,
        output stall_count
    );

    modport master (
        output if_valid, if_instr, if_pc_plus4, flush,
        output wb_reg_write, wb_waddr, wb_wd,
        input  id_ready, ex_valid, ex_rs_val, ex_rt_val, ex_imm_ext, ex_shamt,
        input  ex_rs, ex_rt, ex_rd, ex_is_load, ex_pc_plus4, ex_jump_target,
        input  stall_count
    );
endinterface

// File: rtl/id_stage_hz.sv
// id_stage_hz: MIPS-style decode stage. Holds the register file (2 async
// reads with write-through bypass from WB, 1 sync write), extends immediates,
// forms the jump target, and registers everything into an ID/EX stage.
// A load in EX whose destination is a source of the instruction in ID causes
// a one-cycle stall with a bubble; flush from EX kills the ID instruction.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : id_stage_hz_if.slave (if_*, flush, wb_* in; id_ready, ex_*,
//          stall_count out)
module id_stage_hz #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    parameter int SCNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    id_stage_hz_if.slave      bus
);
    localparam int AW = $clog2(NREGS);

    // Indices outside the file, and r0 when hardwired, are neither stored nor
    // bypassed; such reads return 0.
    function automatic logic writable(input logic [4:0] idx);
        return (int'(idx) < NREGS) && !(ZERO_REG != 0 && idx == 5'd0);
    endfunction

    logic [XLEN-1:0] regs [NREGS];

    // Decode
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    assign opcode = bus.if_instr[31:26];
    assign rs     = bus.if_instr[25:21];
    assign rt     = bus.if_instr[20:16];
    assign rd     = bus.if_instr[15:11];
    assign shamt  = bus.if_instr[10:6];
    assign imm    = bus.if_instr[15:0];

    logic [XLEN-1:0] imm_ext;
    always_comb begin
        imm_ext = {{(XLEN-16){imm[15]}}, imm};
        case (opcode)
            6'b001100, 6'b001101, 6'b001110: imm_ext = {{(XLEN-16){1'b0}}, imm};
            6'b001111: imm_ext = {{(XLEN-32){1'b0}}, imm, 16'h0000};
            default: ;
        endcase
    end

    logic [XLEN-1:0] jump_target;
    assign jump_target = {bus.if_pc_plus4[XLEN-1:28], bus.if_instr[25:0], 2'b00};

    // Register reads with WB write-through
    logic [XLEN-1:0] rs_val, rt_val;
    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (writable(rs)) begin
            if (bus.wb_reg_write && bus.wb_waddr == rs) rs_val = bus.wb_wd;
            else                                        rs_val = regs[rs[AW-1:0]];
        end
        if (writable(rt)) begin
            if (bus.wb_reg_write && bus.wb_waddr == rt) rt_val = bus.wb_wd;
            else                                        rt_val = regs[rt[AW-1:0]];
        end
    end

    // ID/EX state
    logic              ex_valid_q, ex_is_load_q;
    logic [XLEN-1:0]   ex_rs_val_q, ex_rt_val_q, ex_imm_q, ex_pc_q, ex_jt_q;
    logic [4:0]        ex_shamt_q, ex_rs_q, ex_rt_q, ex_rd_q;
    logic [SCNT_W-1:0] stall_q;

    // Load-use hazard: rt only counts as a source for R-type, sw, beq, bne.
    logic uses_rt, hazard;
    assign uses_rt = (opcode == 6'b000000) || (opcode == 6'b101011) ||
                     (opcode == 6'b000100) || (opcode == 6'b000101);
    assign hazard  = bus.if_valid && ex_valid_q && ex_is_load_q && (ex_rt_q != 5'd0) &&
                     ((ex_rt_q == rs) || (uses_rt && ex_rt_q == rt));

    assign bus.id_ready = !hazard || bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (bus.wb_reg_write && writable(bus.wb_waddr)) begin
            regs[bus.wb_waddr[AW-1:0]] <= bus.wb_wd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            ex_is_load_q <= 1'b0;
            ex_rs_val_q  <= '0;
            ex_rt_val_q  <= '0;
            ex_imm_q     <= '0;
            ex_pc_q      <= '0;
            ex_jt_q      <= '0;
            ex_shamt_q   <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_rd_q      <= '0;
            stall_q      <= '0;
        end else if (bus.flush) begin
            // Flush wins over a hazard and is not counted as a stall.
            ex_valid_q   <= 1'b0;
            ex_is_load_q <= 1'b0;
        end else if (hazard) begin
            // Clearing ex_is_load in the bubble bounds every stall to 1 cycle.
            ex_valid_q   <= 1'b0;
            ex_is_load_q <= 1'b0;
            if (stall_q != {SCNT_W{1'b1}}) stall_q <= stall_q + 1'b1;
        end else begin
            ex_valid_q   <= bus.if_valid;
            ex_is_load_q <= bus.if_valid && (opcode == 6'b100011);
            ex_rs_val_q  <= rs_val;
            ex_rt_val_q  <= rt_val;
            ex_imm_q     <= imm_ext;
            ex_pc_q      <= bus.if_pc_plus4;
            ex_jt_q      <= jump_target;
            ex_shamt_q   <= shamt;
            ex_rs_q      <= rs;
            ex_rt_q      <= rt;
            ex_rd_q      <= rd;
        end
    end

    assign bus.ex_valid       = ex_valid_q;
    assign bus.ex_is_load     = ex_is_load_q;
    assign bus.ex_rs_val      = ex_rs_val_q;
    assign bus.ex_rt_val      = ex_rt_val_q;
    assign bus.ex_imm_ext     = ex_imm_q;
    assign bus.ex_pc_plus4    = ex_pc_q;
    assign bus.ex_jump_target = ex_jt_q;
    assign bus.ex_shamt       = ex_shamt_q;
    assign bus.ex_rs          = ex_rs_q;
    assign bus.ex_rt          = ex_rt_q;
    assign bus.ex_rd          = ex_rd_q;
    assign bus.stall_count    = stall_q;
endmodule

// File: tb/tb_id_stage_hz.sv
// tb_id_stage_hz: directed-vector bench for id_stage_hz. Two instances share
// one stimulus stream: dut_a with the default 16-bit stall counter and dut_b
// with a 2-bit counter to exercise saturation.
module tb_id_stage_hz;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        if_valid = 1'b0;
    logic [31:0] if_instr = '0;
    logic [31:0] if_pc_plus4 = '0;
    logic        flush = 1'b0;
    logic        wb_reg_write = 1'b0;
    logic [4:0]  wb_waddr = '0;
    logic [31:0] wb_wd = '0;

    id_stage_hz_if #(.XLEN(32), .SCNT_W(16)) bus_a ();
    id_stage_hz_if #(.XLEN(32), .SCNT_W(2))  bus_b ();

    assign bus_a.if_valid = if_valid;      assign bus_b.if_valid = if_valid;
    assign bus_a.if_instr = if_instr;      assign bus_b.if_instr = if_instr;
    assign bus_a.if_pc_plus4 = if_pc_plus4; assign bus_b.if_pc_plus4 = if_pc_plus4;
    assign bus_a.flush = flush;            assign bus_b.flush = flush;
    assign bus_a.wb_reg_write = wb_reg_write; assign bus_b.wb_reg_write = wb_reg_write;
    assign bus_a.wb_waddr = wb_waddr;      assign bus_b.wb_waddr = wb_waddr;
    assign bus_a.wb_wd = wb_wd;            assign bus_b.wb_wd = wb_wd;

    id_stage_hz #(.XLEN(32), .NREGS(32), .ZERO_REG(1), .SCNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a));
    id_stage_hz #(.XLEN(32), .NREGS(32), .ZERO_REG(1), .SCNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] funct);
        return {6'b000000, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_ADDI = 6'b001000,
                           OP_ORI = 6'b001101, OP_LUI = 6'b001111;

    // Issue lw r8,0(r2) and let it reach EX.
    task automatic issue_lw_r8();
        if_valid = 1'b1;
        if_instr = i_type(OP_LW, 5'd2, 5'd8, 16'h0000);
        tick();
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_ex_valid", bus_a.ex_valid, 0);
        chk("rst_stall", bus_a.stall_count, 0);
        chk("rst_rs_val", bus_a.ex_rs_val, 0);
        chk("rst_id_ready", bus_a.id_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Write r5, then read it from the following instruction
        wb_reg_write = 1'b1; wb_waddr = 5'd5; wb_wd = 32'hDEADBEEF;
        tick();
        wb_reg_write = 1'b0;
        if_valid = 1'b1;
        if_instr = r_type(5'd5, 5'd5, 5'd3, 6'h20);
        if_pc_plus4 = 32'h0000_0104;
        tick();
        chk("add_valid", bus_a.ex_valid, 1);
        chk("add_rs_val", bus_a.ex_rs_val, 32'hDEADBEEF);
        chk("add_rt_val", bus_a.ex_rt_val, 32'hDEADBEEF);
        chk("add_rd", bus_a.ex_rd, 3);
        chk("add_pc", bus_a.ex_pc_plus4, 32'h0000_0104);

        // Same-cycle write-through bypass
        wb_reg_write = 1'b1; wb_waddr = 5'd7; wb_wd = 32'h0000_1234;
        if_instr = r_type(5'd7, 5'd0, 5'd1, 6'h25);
        tick();
        chk("bypass_rs", bus_a.ex_rs_val, 32'h1234);
        chk("bypass_rt0", bus_a.ex_rt_val, 0);
        // r0 write ignored and not bypassed
        wb_waddr = 5'd0; wb_wd = 32'h0000_FFFF;
        if_instr = r_type(5'd0, 5'd0, 5'd2, 6'h20);
        tick();
        chk("r0_bypass_rs", bus_a.ex_rs_val, 0);
        wb_reg_write = 1'b0;
        if_instr = r_type(5'd7, 5'd0, 5'd1, 6'h25);
        tick();
        chk("r7_stored", bus_a.ex_rs_val, 32'h1234);
        chk("r0_stored", bus_a.ex_rt_val, 0);

        // Load-use on rs of an R-type
        issue_lw_r8();
        chk("lw_is_load", bus_a.ex_is_load, 1);
        if_instr = r_type(5'd8, 5'd1, 5'd9, 6'h20);
        #1;
        chk("lu_ready0", bus_a.id_ready, 0);
        tick();
        chk("lu_bubble", bus_a.ex_valid, 0);
        chk("lu_stall1", bus_a.stall_count, 1);
        chk("lu_ready1", bus_a.id_ready, 1);
        tick();
        chk("lu_issue_valid", bus_a.ex_valid, 1);
        chk("lu_issue_rs", bus_a.ex_rs, 8);
        chk("lu_issue_rd", bus_a.ex_rd, 9);

        // addi r8,r8,5: stalls via rs
        issue_lw_r8();
        if_instr = i_type(OP_ADDI, 5'd8, 5'd8, 16'd5);
        #1;
        chk("addi_rs_ready0", bus_a.id_ready, 0);
        tick();
        chk("addi_stall2", bus_a.stall_count, 2);
        tick();
        chk("addi_imm", bus_a.ex_imm_ext, 5);

        // addi r4,r0,1: no dependency
        issue_lw_r8();
        if_instr = i_type(OP_ADDI, 5'd0, 5'd4, 16'd1);
        #1;
        chk("addi_nodep_ready", bus_a.id_ready, 1);
        tick();
        chk("addi_nodep_valid", bus_a.ex_valid, 1);
        chk("addi_nodep_rt", bus_a.ex_rt, 4);

        // ori r8,r1,3: rt is a destination, not a source
        issue_lw_r8();
        if_instr = i_type(OP_ORI, 5'd1, 5'd8, 16'd3);
        #1;
        chk("ori_rt_ready", bus_a.id_ready, 1);
        tick();

        // sw r8,0(r1): rt is a source
        issue_lw_r8();
        if_instr = i_type(OP_SW, 5'd1, 5'd8, 16'd0);
        #1;
        chk("sw_rt_ready0", bus_a.id_ready, 0);
        tick();
        chk("sw_stall3", bus_a.stall_count, 3);
        chk("sw_stall3_b", bus_b.stall_count, 3);
        tick();

        // Immediate extension and jump target
        if_instr = i_type(OP_ADDI, 5'd0, 5'd1, 16'h8001);
        tick();
        chk("imm_addi", bus_a.ex_imm_ext, 32'hFFFF8001);
        if_instr = i_type(OP_ORI, 5'd0, 5'd1, 16'h8001);
        tick();
        chk("imm_ori", bus_a.ex_imm_ext, 32'h00008001);
        if_instr = i_type(OP_LUI, 5'd0, 5'd1, 16'h8001);
        tick();
        chk("imm_lui", bus_a.ex_imm_ext, 32'h80010000);
        if_instr = {6'b000010, 26'h0000040};
        if_pc_plus4 = 32'h1000_0004;
        tick();
        chk("jump_target", bus_a.ex_jump_target, 32'h1000_0100);

        // Flush on a hazard cycle
        issue_lw_r8();
        if_instr = r_type(5'd8, 5'd1, 5'd9, 6'h20);
        flush = 1'b1;
        #1;
        chk("flush_ready", bus_a.id_ready, 1);
        tick();
        flush = 1'b0;
        chk("flush_valid", bus_a.ex_valid, 0);
        chk("flush_stall", bus_a.stall_count, 3);

        // if_valid low loads an empty slot
        if_valid = 1'b0;
        tick();
        chk("idle_valid", bus_a.ex_valid, 0);
        chk("idle_is_load", bus_a.ex_is_load, 0);

        // Two more load-use stalls: dut_a 5, dut_b saturated at 3
        for (int i = 0; i < 2; i++) begin
            issue_lw_r8();
            if_instr = r_type(5'd8, 5'd1, 5'd9, 6'h20);
            tick();
            tick();
        end
        chk("stall5_a", bus_a.stall_count, 5);
        chk("stall_sat_b", bus_b.stall_count, 3);

        // Reset in the middle of a stall
        issue_lw_r8();
        if_instr = r_type(5'd8, 5'd1, 5'd9, 6'h20);
        #1;
        chk("pre_rst_ready0", bus_a.id_ready, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", bus_a.ex_valid, 0);
        chk("mid_rst_stall", bus_a.stall_count, 0);
        chk("mid_rst_stall_b", bus_b.stall_count, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", bus_a.id_ready, 1);
        tick();
        chk("post_rst_issue", bus_a.ex_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/id_stage_hz.md
Name: id_stage_hz

Overview:
- Parametrised decode stage: register file, immediate extension, jump-target generation and WB-to-ID write-through bypass.
- Adds a registered ID/EX output stage with a valid bit and an upstream ready handshake.
- Adds load-use hazard detection that stalls the stage and inserts a bubble, flush from EX, and a saturating stall counter.
- Sits between the IF/ID register and the EX stage.

Parameters:
- XLEN, 32, datapath width in bits (≥32). Immediates and jump target are extended to XLEN.
- NREGS, 32, number of architectural registers (2..32). Register indices ≥ NREGS read 0 and are never written.
- ZERO_REG, 1, 1 = register 0 hardwired to 0 (writes ignored, never bypassed). 0 = register 0 is an ordinary register.
- SCNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- if_valid  in  1  if_instr/if_pc_plus4 hold a real instruction
- if_instr  in  32  instruction word, MIPS encoding
- if_pc_plus4  in  XLEN  PC+4 of if_instr
- id_ready  out  1  stage accepts if_instr this cycle; upstream holds when 0
- flush  in  1  kill the instruction in ID (branch/jump taken in EX)
- wb_reg_write  in  1  write-back enable
- wb_waddr  in  5  write-back register index
- wb_wd  in  XLEN  write-back data
- ex_valid  out  1  ID/EX register holds a real instruction
- ex_rs_val, ex_rt_val  out  XLEN  operand values
- ex_imm_ext  out  XLEN  extended immediate
- ex_shamt  out  5  instr[10:6]
- ex_rs, ex_rt, ex_rd  out  5  register fields
- ex_is_load  out  1  instruction is lw (opcode 100011)
- ex_pc_plus4  out  XLEN  registered PC+4
- ex_jump_target  out  XLEN  {pc_plus4[XLEN-1:28], instr[25:0], 2'b00}
- stall_count  out  SCNT_W  number of load-use stall cycles, saturating

Behaviour:
- Reset (async, immediate): all ex_* outputs = 0, ex_valid = 0, stall_count = 0, every register-file entry = 0.
- Field decode is combinational from if_instr: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6].
- Immediate extension:
  - andi/ori/xori (001100/001101/001110): zero-extend.
  - lui (001111): imm << 16, then zero-extend to XLEN.
  - all other opcodes: sign-extend instr[15:0].
- Register file: 2 asynchronous read ports and 1 write port, written on rising clk when wb_reg_write=1.
- Write-through bypass: if wb_reg_write, wb_waddr==rs and the index is writable, rs read value = wb_wd in the same cycle. Same rule for rt.
  - "Writable" means index < NREGS and not (ZERO_REG and index==0).
- uses_rt = opcode ∈ {000000, 101011 sw, 000100 beq, 000101 bne}.
- hazard = if_valid & ex_valid & ex_is_load & ex_rt!=0 & (ex_rt==rs | (uses_rt & ex_rt==rt)).
- id_ready = ~hazard | flush.
- Per-cycle update of the ID/EX register (priority order):
  1. flush=1: ex_valid←0. The instruction in ID is consumed (id_ready=1). No stall is counted, even if hazard=1.
  2. hazard=1: ex_valid←0 (bubble). Other ex_* fields are don't-care but must not create a new hazard, so ex_is_load←0. stall_count increments, saturating at 2^SCNT_W-1.
  3. otherwise: ex_valid←if_valid and all fields load from the decode. When if_valid=0, ex_is_load←0.
- Latency: 1 cycle from acceptance to ex_valid.
- A stalled instruction is re-evaluated on the next cycle. The bubble clears ex_is_load, so a stall never exceeds 1 cycle per load.
- A write and a read of the same index in the same cycle return the new data via the bypass. The stored value is visible from the next cycle on.
- Reset asserted mid-stall: ex_valid=0 and stall_count=0 immediately; id_ready=1 after release.

Test Plan:
- Reset, then write-back r5=0xDEADBEEF; next cycle `add r3,r5,r5` -> ex_rs_val = ex_rt_val = 0xDEADBEEF, ex_valid=1 one cycle later.
- wb writes r7=0x1234 in the same cycle `or r1,r7,r0` is in ID -> ex_rs_val=0x1234 (bypass). Also write r0=0xFFFF with ZERO_REG=1 -> r0 reads 0.
- `lw r8,0(r2)` followed by `add r9,r8,r1` -> id_ready=0 for exactly 1 cycle, one bubble (ex_valid=0), stall_count=1, then add issues with ex_rs=8.
- `lw r8` followed by `addi r8,r8,...` (rt not used as a source) stalls only on rs. `lw r8` followed by `addi r4,r0,1` -> no stall.
- Immediate 0x8001: addi -> 0xFFFF8001; ori -> 0x00008001; lui -> 0x80010000. j with target 0x0000040 and pc_plus4=0x10000004 -> ex_jump_target=0x10000100.
- flush asserted on a hazard cycle -> id_ready=1, ex_valid=0, stall_count unchanged. With SCNT_W=2, five stall cycles -> stall_count=3.
